// File: rtl/cpu_fwd_pipe.sv
// cpu_fwd_pipe: 5-stage in-order core (IF/ID/EX/MEM/WB) with a 4-op ALU, operand forwarding,
// load-use stall, regfile write-through, global freeze and a retire port.
module cpu_fwd_pipe #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned PC_W        = 9,
    parameter int unsigned DMEM_ADDR_W = 8,
    parameter int unsigned REG_ADDR_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeze_i,
    input  logic [INSTR_W-1:0]     i_mem_data_i,
    output logic [PC_W-1:0]        i_mem_addr_o,
    input  logic [DATA_W-1:0]      d_mem_data_i,
    output logic [DMEM_ADDR_W-1:0] d_mem_addr_o,
    output logic [DATA_W-1:0]      d_mem_data_o,
    output logic                   d_mem_wen_o,
    output logic                   wb_valid_o,
    output logic [REG_ADDR_W-1:0]  wb_addr_o,
    output logic [DATA_W-1:0]      wb_data_o
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_W;
    localparam int unsigned UsedW   = 5 + 3 * REG_ADDR_W;
    localparam int unsigned MwBit   = INSTR_W - 1;
    localparam int unsigned RwBit   = INSTR_W - 2;
    localparam int unsigned MrBit   = INSTR_W - 3;
    localparam int unsigned OpHi    = INSTR_W - 4;
    localparam int unsigned RaHi    = INSTR_W - 6;
    localparam int unsigned RbHi    = RaHi - REG_ADDR_W;
    localparam int unsigned RdHi    = RbHi - REG_ADDR_W;

    localparam logic [1:0] OpPass = 2'b00;
    localparam logic [1:0] OpAdd  = 2'b01;
    localparam logic [1:0] OpSub  = 2'b10;
    localparam logic [1:0] OpXor  = 2'b11;

    // IF
    logic [PC_W-1:0]       pc_q;
    logic [PC_W-1:0]       pc_d;
    logic [INSTR_W-1:0]    ifid_instr_q;

    // ID
    logic                  id_mw;
    logic                  id_rw;
    logic                  id_mr;
    logic [1:0]            id_op;
    logic [REG_ADDR_W-1:0] id_ra;
    logic [REG_ADDR_W-1:0] id_rb;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [DATA_W-1:0]     id_a;
    logic [DATA_W-1:0]     id_b;
    logic                  load_use;

    logic                  idex_mw_q;
    logic                  idex_rw_q;
    logic                  idex_mr_q;
    logic [1:0]            idex_op_q;
    logic [REG_ADDR_W-1:0] idex_ra_q;
    logic [REG_ADDR_W-1:0] idex_rb_q;
    logic [REG_ADDR_W-1:0] idex_rd_q;
    logic [DATA_W-1:0]     idex_a_q;
    logic [DATA_W-1:0]     idex_b_q;

    // EX
    logic [DATA_W-1:0]     ex_a;
    logic [DATA_W-1:0]     ex_b;
    logic [DATA_W-1:0]     ex_alu;

    logic                  exmem_mw_q;
    logic                  exmem_rw_q;
    logic                  exmem_mr_q;
    logic [REG_ADDR_W-1:0] exmem_rd_q;
    logic [DATA_W-1:0]     exmem_alu_q;
    logic [DMEM_ADDR_W-1:0] exmem_addr_q;
    logic [DATA_W-1:0]     exmem_b_q;

    // MEM/WB
    logic                  memwb_rw_q;
    logic                  memwb_mr_q;
    logic [REG_ADDR_W-1:0] memwb_rd_q;
    logic [DATA_W-1:0]     memwb_alu_q;
    logic [DATA_W-1:0]     memwb_mdata_q;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_we;

    logic [DATA_W-1:0]     regs_q [NumRegs];

    // ---------------------------------------------------------------- IF
    assign pc_d = pc_q + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            ifid_instr_q <= '0;
        end else if (!freeze_i && !load_use) begin
            pc_q         <= pc_d;
            ifid_instr_q <= i_mem_data_i;
        end
    end

    // ---------------------------------------------------------------- ID
    assign id_mw = ifid_instr_q[MwBit];
    assign id_rw = ifid_instr_q[RwBit];
    assign id_mr = ifid_instr_q[MrBit];
    assign id_op = ifid_instr_q[OpHi -: 2];
    assign id_ra = ifid_instr_q[RaHi -: REG_ADDR_W];
    assign id_rb = ifid_instr_q[RbHi -: REG_ADDR_W];
    assign id_rd = ifid_instr_q[RdHi -: REG_ADDR_W];

    if (UsedW < INSTR_W) begin : g_spare_bits
        logic unused_spare;
        assign unused_spare = ^ifid_instr_q[INSTR_W-UsedW-1:0];
    end

    // Write-through: a retiring write is visible to the ID read in the same cycle.
    always_comb begin
        id_a = regs_q[id_ra];
        id_b = regs_q[id_rb];
        if (memwb_rw_q && (memwb_rd_q == id_ra)) begin
            id_a = wb_data;
        end
        if (memwb_rw_q && (memwb_rd_q == id_rb)) begin
            id_b = wb_data;
        end
    end

    assign load_use = idex_rw_q && idex_mr_q &&
                      ((idex_rd_q == id_ra) || (idex_rd_q == id_rb));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_mw_q <= 1'b0;
            idex_rw_q <= 1'b0;
            idex_mr_q <= 1'b0;
            idex_op_q <= '0;
            idex_ra_q <= '0;
            idex_rb_q <= '0;
            idex_rd_q <= '0;
            idex_a_q  <= '0;
            idex_b_q  <= '0;
        end else if (!freeze_i) begin
            if (load_use) begin
                idex_mw_q <= 1'b0;
                idex_rw_q <= 1'b0;
                idex_mr_q <= 1'b0;
                idex_op_q <= '0;
                idex_ra_q <= '0;
                idex_rb_q <= '0;
                idex_rd_q <= '0;
                idex_a_q  <= '0;
                idex_b_q  <= '0;
            end else begin
                idex_mw_q <= id_mw;
                idex_rw_q <= id_rw;
                idex_mr_q <= id_mr;
                idex_op_q <= id_op;
                idex_ra_q <= id_ra;
                idex_rb_q <= id_rb;
                idex_rd_q <= id_rd;
                idex_a_q  <= id_a;
                idex_b_q  <= id_b;
            end
        end
    end

    // ---------------------------------------------------------------- EX
    // Loads in EX/MEM cannot forward yet; the load-use stall guarantees they come via MEM/WB.
    always_comb begin
        ex_a = idex_a_q;
        if (exmem_rw_q && !exmem_mr_q && (exmem_rd_q == idex_ra_q)) begin
            ex_a = exmem_alu_q;
        end else if (memwb_rw_q && (memwb_rd_q == idex_ra_q)) begin
            ex_a = wb_data;
        end
    end

    always_comb begin
        ex_b = idex_b_q;
        if (exmem_rw_q && !exmem_mr_q && (exmem_rd_q == idex_rb_q)) begin
            ex_b = exmem_alu_q;
        end else if (memwb_rw_q && (memwb_rd_q == idex_rb_q)) begin
            ex_b = wb_data;
        end
    end

    always_comb begin
        ex_alu = ex_a;
        unique case (idex_op_q)
            OpPass:  ex_alu = ex_a;
            OpAdd:   ex_alu = ex_a + ex_b;
            OpSub:   ex_alu = ex_a - ex_b;
            OpXor:   ex_alu = ex_a ^ ex_b;
            default: ex_alu = ex_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_mw_q   <= 1'b0;
            exmem_rw_q   <= 1'b0;
            exmem_mr_q   <= 1'b0;
            exmem_rd_q   <= '0;
            exmem_alu_q  <= '0;
            exmem_addr_q <= '0;
            exmem_b_q    <= '0;
        end else if (!freeze_i) begin
            exmem_mw_q   <= idex_mw_q;
            exmem_rw_q   <= idex_rw_q;
            exmem_mr_q   <= idex_mr_q;
            exmem_rd_q   <= idex_rd_q;
            exmem_alu_q  <= ex_alu;
            exmem_addr_q <= ex_a[DMEM_ADDR_W-1:0];
            exmem_b_q    <= ex_b;
        end
    end

    // ---------------------------------------------------------------- MEM
    assign d_mem_addr_o = exmem_addr_q;
    assign d_mem_data_o = exmem_b_q;
    assign d_mem_wen_o  = exmem_mw_q && !freeze_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_rw_q    <= 1'b0;
            memwb_mr_q    <= 1'b0;
            memwb_rd_q    <= '0;
            memwb_alu_q   <= '0;
            memwb_mdata_q <= '0;
        end else if (!freeze_i) begin
            memwb_rw_q    <= exmem_rw_q;
            memwb_mr_q    <= exmem_mr_q;
            memwb_rd_q    <= exmem_rd_q;
            memwb_alu_q   <= exmem_alu_q;
            memwb_mdata_q <= d_mem_data_i;
        end
    end

    // ---------------------------------------------------------------- WB
    assign wb_data = memwb_mr_q ? memwb_mdata_q : memwb_alu_q;
    assign wb_we   = memwb_rw_q && !freeze_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[memwb_rd_q] <= wb_data;
        end
    end

    assign i_mem_addr_o = pc_q;
    assign wb_valid_o   = wb_we;
    assign wb_addr_o    = memwb_rd_q;
    assign wb_data_o    = wb_data;

endmodule

// File: tb/tb_cpu_fwd_pipe.sv
// Bench for cpu_fwd_pipe: directed programs plus a random program, checked every cycle against
// a sequential instruction-set model with a stall-count timing rule.
module tb_cpu_fwd_pipe;

    localparam int unsigned DW   = 64;
    localparam int unsigned IW   = 32;
    localparam int unsigned PW   = 9;
    localparam int unsigned AW   = 8;
    localparam int unsigned RAW  = 2;
    localparam int          NPC  = 512;
    localparam int          MAXC = 600;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           freeze_i = 1'b0;
    logic [IW-1:0]  i_mem_data_i;
    logic [PW-1:0]  i_mem_addr_o;
    logic [DW-1:0]  d_mem_data_i;
    logic [AW-1:0]  d_mem_addr_o;
    logic [DW-1:0]  d_mem_data_o;
    logic           d_mem_wen_o;
    logic           wb_valid_o;
    logic [RAW-1:0] wb_addr_o;
    logic [DW-1:0]  wb_data_o;

    logic [IW-1:0]  imem [NPC];
    logic [DW-1:0]  dmem [256];

    // expected per active cycle
    logic           exp_wbv [MAXC+1];
    logic [1:0]     exp_wba [MAXC+1];
    logic [DW-1:0]  exp_wbd [MAXC+1];
    logic           exp_wen [MAXC+1];
    logic [7:0]     exp_da  [MAXC+1];
    logic [DW-1:0]  exp_dd  [MAXC+1];
    logic [PW-1:0]  exp_pc  [MAXC+1];

    logic [DW-1:0]  obs_reg [4];
    int             st_cnt;
    logic [7:0]     st_addr;
    logic [DW-1:0]  st_data;
    bit             seen_top;
    bit             wrap_seen;

    int checks;
    int errors;
    int n;

    cpu_fwd_pipe #(
        .DATA_W     (DW),
        .INSTR_W    (IW),
        .PC_W       (PW),
        .DMEM_ADDR_W(AW),
        .REG_ADDR_W (RAW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .freeze_i    (freeze_i),
        .i_mem_data_i(i_mem_data_i),
        .i_mem_addr_o(i_mem_addr_o),
        .d_mem_data_i(d_mem_data_i),
        .d_mem_addr_o(d_mem_addr_o),
        .d_mem_data_o(d_mem_data_o),
        .d_mem_wen_o (d_mem_wen_o),
        .wb_valid_o  (wb_valid_o),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o)
    );

    assign i_mem_data_i = imem[i_mem_addr_o];
    assign d_mem_data_i = dmem[d_mem_addr_o];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit mw, input bit rw, input bit mr,
                                       input logic [1:0] op, input logic [1:0] ra,
                                       input logic [1:0] rb, input logic [1:0] rd);
        return {mw, rw, mr, op, ra, rb, rd, 21'd0};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < NPC; i++) imem[i] = '0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
    endtask

    // Executes the program one instruction at a time; instruction k retires k+4+S cycles after
    // reset release, where S counts load-use pairs among instructions 1..k.
    task automatic build(input int ncyc);
        logic [DW-1:0] r [4];
        logic [DW-1:0] m [256];
        logic [IW-1:0] ins;
        logic          mw, rw, mr;
        logic [1:0]    op, ra, rb, rd, prev_rd;
        logic [DW-1:0] a, b, alu, ld, res;
        int            s, f, t, dur;
        bit            st, prev_st, prev_ld;
        for (int i = 0; i < 4; i++) r[i] = '0;
        for (int i = 0; i < 256; i++) m[i] = dmem[i];
        for (int i = 0; i <= MAXC; i++) begin
            exp_wbv[i] = 1'b0; exp_wba[i] = '0; exp_wbd[i] = '0;
            exp_wen[i] = 1'b0; exp_da[i] = '0;  exp_dd[i] = '0; exp_pc[i] = '0;
        end
        s = 0; f = 0; prev_st = 0; prev_ld = 0; prev_rd = '0;
        for (int k = 0; k <= ncyc; k++) begin
            ins = imem[k % NPC];
            mw = ins[31]; rw = ins[30]; mr = ins[29]; op = ins[28:27];
            ra = ins[26:25]; rb = ins[24:23]; rd = ins[22:21];
            st = prev_ld && (prev_rd == ra || prev_rd == rb);
            dur = prev_st ? 2 : 1;
            for (int j = 0; j < dur; j++) begin
                if (f <= MAXC) exp_pc[f] = PW'(k % NPC);
                f++;
            end
            if (st) s++;
            a = r[ra];
            b = r[rb];
            case (op)
                2'd0: alu = a;
                2'd1: alu = a + b;
                2'd2: alu = a - b;
                default: alu = a ^ b;
            endcase
            ld = m[a[7:0]];
            if (mw) begin
                m[a[7:0]] = b;
                t = k + 3 + s;
                if (t <= MAXC) begin exp_wen[t] = 1'b1; exp_da[t] = a[7:0]; exp_dd[t] = b; end
            end
            res = mr ? ld : alu;
            if (rw) begin
                r[rd] = res;
                t = k + 4 + s;
                if (t <= MAXC) begin exp_wbv[t] = 1'b1; exp_wba[t] = rd; exp_wbd[t] = res; end
            end
            prev_st = st;
            prev_ld = rw && mr;
            prev_rd = rd;
        end
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        rst_n    = 1'b0;
        freeze_i = 1'b0;
        #1;
        chk("rst_pc", 64'(i_mem_addr_o), 64'd0);
        chk("rst_wen", 64'(d_mem_wen_o), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_wb_data", wb_data_o, 64'd0);
        chk("rst_daddr", 64'(d_mem_addr_o), 64'd0);
        for (int i = 0; i < 4; i++) obs_reg[i] = '0;
        st_cnt = 0; st_addr = '0; st_data = '0; seen_top = 0; wrap_seen = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sample();
        chk("pc", 64'(i_mem_addr_o), 64'(exp_pc[n]));
        if (freeze_i) begin
            chk("frz_wb_valid", 64'(wb_valid_o), 64'd0);
            chk("frz_wen", 64'(d_mem_wen_o), 64'd0);
        end else begin
            chk("wb_valid", 64'(wb_valid_o), 64'(exp_wbv[n]));
            if (exp_wbv[n]) begin
                chk("wb_addr", 64'(wb_addr_o), 64'(exp_wba[n]));
                chk("wb_data", wb_data_o, exp_wbd[n]);
            end
            chk("wen", 64'(d_mem_wen_o), 64'(exp_wen[n]));
            if (exp_wen[n]) begin
                chk("st_addr", 64'(d_mem_addr_o), 64'(exp_da[n]));
                chk("st_data", d_mem_data_o, exp_dd[n]);
            end
        end
        if (wb_valid_o) obs_reg[wb_addr_o] = wb_data_o;
        if (d_mem_wen_o) begin st_cnt++; st_addr = d_mem_addr_o; st_data = d_mem_data_o; end
        if (i_mem_addr_o == PW'(NPC - 1)) seen_top = 1;
        if (seen_top && i_mem_addr_o == '0) wrap_seen = 1;
    endtask

    task automatic run_seg(input int ncyc, input bit rnd_frz);
        bit            pend;
        logic [7:0]    pa;
        logic [DW-1:0] pd;
        n = 0;
        for (int t = 0; t < ncyc; t++) begin
            freeze_i = (rnd_frz && t >= 20 && t < 23) ||
                       (rnd_frz && t > 60 && $urandom_range(0, 9) == 0);
            #1;
            sample();
            pend = d_mem_wen_o;
            pa   = d_mem_addr_o;
            pd   = d_mem_data_o;
            @(posedge clk);
            #1;
            if (pend) dmem[pa] = pd;
            if (!freeze_i) n++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [IW-1:0] ins;
        checks = 0;
        errors = 0;
        @(negedge clk);

        // NOP stream
        clear_mem();
        build(30);
        do_reset();
        run_seg(30, 0);

        // two loads then dependent add
        clear_mem();
        dmem[0] = 64'd5;
        imem[0] = mk(0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd1);
        imem[1] = mk(0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd2);
        imem[2] = mk(0, 1, 0, 2'd1, 2'd1, 2'd2, 2'd3);
        build(20);
        do_reset();
        run_seg(20, 0);
        chk("a_r1", obs_reg[1], 64'd5);
        chk("a_r3", obs_reg[3], 64'd10);

        // forwarding chain
        clear_mem();
        dmem[0] = 64'd7;
        imem[0] = mk(0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd1);
        imem[1] = mk(0, 1, 0, 2'd1, 2'd1, 2'd1, 2'd2);
        imem[2] = mk(0, 1, 0, 2'd2, 2'd2, 2'd1, 2'd3);
        imem[3] = mk(0, 1, 0, 2'd3, 2'd3, 2'd2, 2'd0);
        build(20);
        do_reset();
        run_seg(20, 0);
        chk("b_r2", obs_reg[2], 64'd14);
        chk("b_r3", obs_reg[3], 64'd7);
        chk("b_r0", obs_reg[0], 64'd9);

        // store right after the load of its data
        clear_mem();
        dmem[0] = 64'd7;
        imem[0] = mk(0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd1);
        imem[1] = mk(1, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0);
        build(20);
        do_reset();
        run_seg(20, 0);
        chk("c_st_cnt", 64'(st_cnt), 64'd1);
        chk("c_st_addr", 64'(st_addr), 64'd0);
        chk("c_st_data", st_data, 64'd7);

        // random program with freezes, cut short by the next reset
        clear_mem();
        for (int i = 0; i < 256; i++) dmem[i] = {$urandom, $urandom};
        for (int i = 0; i < 160; i++) begin
            ins     = $urandom;
            ins[31] = ($urandom_range(0, 3) == 0);
            ins[30] = ($urandom_range(0, 3) != 0);
            ins[29] = ($urandom_range(0, 2) == 0);
            imem[i] = ins;
        end
        build(200);
        do_reset();
        run_seg(200, 1);

        // 0 - 1 wraps, and the PC wraps past the top of instruction memory
        clear_mem();
        dmem[0] = 64'd1;
        imem[0] = mk(0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd1);
        imem[1] = mk(0, 1, 0, 2'd2, 2'd0, 2'd1, 2'd2);
        build(530);
        do_reset();
        run_seg(530, 0);
        chk("d_sub_wrap", obs_reg[2], {64{1'b1}});
        chk("d_pc_wrap", 64'(wrap_seen), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
